// File: rtl/cnn_image_streamer_pkg.sv
// Shared constants, FSM encoding and the non-negative float max helper for the
// CNN pixel interface.
package cnn_image_streamer_pkg;

    localparam int CNN_IMG_W      = 28;
    localparam int CNN_IMG_H      = 28;
    localparam int CNN_IMG_PIXELS = CNN_IMG_W * CNN_IMG_H;
    localparam int CNN_DATA_W     = 32;
    localparam int CNN_ADDR_W     = 10;
    localparam int CNN_DEC_W      = 4;
    localparam int CNN_TIMEOUT    = 4095;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // For non-negative IEEE-754 values the magnitude bits order like an
    // unsigned integer; negative words count as zero and can never win.
    function automatic logic [CNN_DATA_W-1:0] fp_pos_max(
        input logic [CNN_DATA_W-1:0] acc,
        input logic [CNN_DATA_W-1:0] word
    );
        logic [CNN_DATA_W-1:0] res;
        if (!word[CNN_DATA_W-1] && (word[CNN_DATA_W-2:0] > acc[CNN_DATA_W-2:0])) begin
            res = word;
        end else begin
            res = acc;
        end
        return res;
    endfunction

endpackage

// File: rtl/cnn_image_streamer.sv
// Transmit side of the CNN pixel interface: scans one image for its max, streams
// it pixel by pixel into the CNN top, then collects the decision or times out.
module cnn_image_streamer
    import cnn_image_streamer_pkg::*;
#(
    parameter int IMG_PIXELS = CNN_IMG_PIXELS,
    parameter int DATA_W     = CNN_DATA_W,
    parameter int ADDR_W     = CNN_ADDR_W,
    parameter int TIMEOUT    = CNN_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 cnn_rst,
    output logic [DATA_W-1:0]    cnn_data,
    output logic [DATA_W-1:0]    cnn_data_max,
    input  logic                 cnn_valid_out,
    input  logic [CNN_DEC_W-1:0] cnn_decision,
    output logic                 done,
    output logic [CNN_DEC_W-1:0] result,
    output logic                 error
);

    localparam int CNT_MAX = (IMG_PIXELS + 1 > TIMEOUT) ? IMG_PIXELS + 1 : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST_ADDR  = CNT_W'(IMG_PIXELS - 1);
    localparam logic [CNT_W-1:0]  CNT_SCAN_END   = CNT_W'(IMG_PIXELS);
    localparam logic [CNT_W-1:0]  CNT_STREAM_END = CNT_W'(IMG_PIXELS + 1);
    localparam logic [CNT_W-1:0]  CNT_TMO_END    = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE       = ADDR_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO      = {DATA_W{1'b0}};

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      acc_q, acc_d;
    logic                   busy_q, busy_d;
    logic                   mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic                   cnn_rst_q, cnn_rst_d;
    logic [DATA_W-1:0]      cnn_data_q, cnn_data_d;
    logic [DATA_W-1:0]      cnn_data_max_q, cnn_data_max_d;
    logic                   done_q, done_d;
    logic [CNN_DEC_W-1:0]   result_q, result_d;
    logic                   error_q, error_d;

    // Next-state and next-output computation for the whole transfer sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        mem_rd_en_d    = 1'b0;
        mem_addr_d     = ADDR_ZERO;
        cnn_rst_d      = cnn_rst_q;
        cnn_data_d     = cnn_data_q;
        cnn_data_max_d = cnn_data_max_q;
        done_d         = 1'b0;
        result_d       = result_q;
        error_d        = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SCAN;
                    cnt_d       = CNT_ZERO;
                    acc_d       = DATA_ZERO;
                    error_d     = 1'b0;
                    mem_rd_en_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // Read data lags the address by one cycle, so count 0 has no word yet.
            ST_SCAN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q != CNT_ZERO) begin
                    acc_d = fp_pos_max(acc_q, mem_rdata);
                end else begin
                    acc_d = acc_q;
                end
                if (cnt_q == CNT_SCAN_END) begin
                    cnn_data_max_d = fp_pos_max(acc_q, mem_rdata);
                    state_d        = ST_STREAM;
                    cnt_d          = CNT_ZERO;
                    mem_rd_en_d    = 1'b1;
                end else if (cnt_q < CNT_LAST_ADDR) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_ONE;
                end else begin
                    mem_rd_en_d = 1'b0;
                end
            end

            ST_STREAM: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q < CNT_LAST_ADDR) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_ONE;
                end else begin
                    mem_rd_en_d = 1'b0;
                end
                if (cnt_q == CNT_STREAM_END) begin
                    cnn_data_d = DATA_ZERO;
                    state_d    = ST_WAIT;
                    cnt_d      = CNT_ZERO;
                end else if (cnt_q != CNT_ZERO) begin
                    cnn_data_d = mem_rdata;
                    cnn_rst_d  = 1'b0;
                end else begin
                    cnn_data_d = cnn_data_q;
                end
            end

            // A decision arriving on the expiry cycle takes priority over the timeout.
            ST_WAIT: begin
                if (cnn_valid_out) begin
                    result_d  = cnn_decision;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    cnn_rst_d = 1'b1;
                end else if (cnt_q == CNT_TMO_END) begin
                    error_d   = 1'b1;
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    cnn_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= CNT_ZERO;
            acc_q          <= DATA_ZERO;
            busy_q         <= 1'b0;
            mem_rd_en_q    <= 1'b0;
            mem_addr_q     <= ADDR_ZERO;
            cnn_rst_q      <= 1'b1;
            cnn_data_q     <= DATA_ZERO;
            cnn_data_max_q <= DATA_ZERO;
            done_q         <= 1'b0;
            result_q       <= {CNN_DEC_W{1'b0}};
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            busy_q         <= busy_d;
            mem_rd_en_q    <= mem_rd_en_d;
            mem_addr_q     <= mem_addr_d;
            cnn_rst_q      <= cnn_rst_d;
            cnn_data_q     <= cnn_data_d;
            cnn_data_max_q <= cnn_data_max_d;
            done_q         <= done_d;
            result_q       <= result_d;
            error_q        <= error_d;
        end
    end

    assign busy         = busy_q;
    assign mem_rd_en    = mem_rd_en_q;
    assign mem_addr     = mem_addr_q;
    assign cnn_rst      = cnn_rst_q;
    assign cnn_data     = cnn_data_q;
    assign cnn_data_max = cnn_data_max_q;
    assign done         = done_q;
    assign result       = result_q;
    assign error        = error_q;

endmodule

// File: tb/tb_cnn_image_streamer.sv
// Self-checking bench: pixel RAM and CNN response models, expected behaviour
// derived from the frame timeline (scan, stream, wait, done) and image contents.
module tb_cnn_image_streamer;

    localparam int IMG     = 784;
    localparam int TMO     = 16;
    localparam int S_N     = IMG + 2;          // first STREAM cycle, counted from the accept edge
    localparam int P0_N    = S_N + 2;          // pixel 0 on cnn_data
    localparam int WAIT0_N = S_N + IMG + 2;    // first WAIT cycle

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        cnn_rst;
    logic [31:0] cnn_data;
    logic [31:0] cnn_data_max;
    logic        cnn_valid_out;
    logic [3:0]  cnn_decision;
    logic        done;
    logic [3:0]  result;
    logic        error;

    logic [31:0] img [IMG];
    logic [3:0]  res_model;
    int          n_tests;
    int          n_fail;

    cnn_image_streamer #(
        .IMG_PIXELS (IMG),
        .DATA_W     (32),
        .ADDR_W     (10),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .cnn_rst       (cnn_rst),
        .cnn_data      (cnn_data),
        .cnn_data_max  (cnn_data_max),
        .cnn_valid_out (cnn_valid_out),
        .cnn_decision  (cnn_decision),
        .done          (done),
        .result        (result),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read pixel RAM.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= (int'(mem_addr) < IMG) ? img[int'(mem_addr)] : 32'hDEAD_BEEF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Real value in [0, 1] to IEEE-754 single bits.
    function automatic logic [31:0] f32_of(input real v);
        int  e;
        int  f;
        real m;
        if (v <= 0.0) return 32'h0000_0000;
        e = 0;
        m = v;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = int'((m - 1.0) * 8388608.0);
        if (f >= 8388608) begin f = 0; e++; end
        return {1'b0, 8'(e + 127), 23'(f)};
    endfunction

    // Largest non-negative pixel; negative pixels count as zero.
    function automatic logic [31:0] ref_max();
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < IMG; i++) begin
            if (!img[i][31] && img[i] > m) m = img[i];
        end
        return m;
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, "_busy"},  busy,         32'd0);
        check_eq({tag, "_rden"},  mem_rd_en,    32'd0);
        check_eq({tag, "_addr"},  mem_addr,     32'd0);
        check_eq({tag, "_crst"},  cnn_rst,      32'd1);
        check_eq({tag, "_data"},  cnn_data,     32'd0);
        check_eq({tag, "_max"},   cnn_data_max, 32'd0);
        check_eq({tag, "_done"},  done,         32'd0);
        check_eq({tag, "_res"},   result,       32'd0);
        check_eq({tag, "_err"},   error,        32'd0);
    endtask

    // One full frame from start; resp_d < 0 means the CNN never answers.
    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_frame(input int resp_d, input logic [3:0] dec, input bit poke);
        int          n_done;
        logic [3:0]  exp_res;
        logic        exp_err;
        logic [31:0] exp_max;
        logic        reading;
        exp_max = ref_max();
        if (resp_d >= 0 && resp_d < TMO) begin
            n_done  = WAIT0_N + resp_d + 1;
            exp_res = dec;
            exp_err = 1'b0;
        end else begin
            n_done  = WAIT0_N + TMO;
            exp_res = res_model;
            exp_err = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= n_done + 1; n++) begin
            reading = (n <= IMG) || (n >= S_N && n < S_N + IMG);
            check_eq("busy", busy, 32'(n <= n_done));
            check_eq("done", done, 32'(n == n_done));
            check_eq("rd_en", mem_rd_en, 32'(reading));
            if (reading) check_eq("addr", mem_addr, 32'((n <= IMG) ? n - 1 : n - S_N));
            check_eq("cnn_rst", cnn_rst, 32'(!(n >= P0_N && n < n_done)));
            check_eq("cnn_data", cnn_data, (n >= P0_N && n < P0_N + IMG) ? img[n - P0_N] : 32'h0);
            if (n >= S_N) check_eq("data_max", cnn_data_max, exp_max);
            check_eq("error", error, (n >= n_done) ? 32'(exp_err) : 32'd0);
            check_eq("result", result, (n >= n_done) ? 32'(exp_res) : 32'(res_model));
            start         = poke && (n == 300 || n == 1000 || n == WAIT0_N + 1);
            cnn_valid_out = (resp_d >= 0 && n == WAIT0_N + resp_d) || (poke && n == 1200);
            cnn_decision  = (resp_d >= 0 && n == WAIT0_N + resp_d) ? dec : 4'($urandom);
            if (n <= n_done) @(negedge clk);
        end
        start         = 1'b0;
        cnn_valid_out = 1'b0;
        res_model     = exp_res;
    endtask

    task automatic load_random_image();
        for (int k = 0; k < IMG; k++) begin
            img[k] = $urandom;
            if (img[k][30:23] == 8'hFF) img[k][30] = 1'b0;
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        res_model     = 4'd0;
        rst           = 1'b1;
        start         = 1'b0;
        cnn_valid_out = 1'b0;
        cnn_decision  = 4'd0;
        for (int k = 0; k < IMG; k++) img[k] = 32'h0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp image k/783, CNN answers with decision 7.
        for (int k = 0; k < IMG; k++) img[k] = f32_of(real'(k) / 783.0);
        run_frame(5, 4'd7, 1'b0);
        check_eq("ramp_max", cnn_data_max, 32'h3F80_0000);
        check_eq("ramp_res", result, 32'd7);

        // No answer: timeout keeps the previous result.
        run_frame(-1, 4'd0, 1'b0);
        check_eq("tmo_err", error, 32'd1);
        check_eq("tmo_res", result, 32'd7);

        // Negative pixels ignored, max +0.5; stray start/valid_out while busy.
        for (int k = 0; k < IMG; k++) begin
            img[k] = f32_of(real'($urandom_range(0, 4999)) / 10000.0);
            if ($urandom_range(0, 3) == 0) img[k][31] = 1'b1;
        end
        img[50]                        = 32'hFF7F_FFFF;
        img[100]                       = 32'hBF80_0000;
        img[$urandom_range(200, 783)]  = 32'h3F00_0000;
        run_frame(3, 4'd9, 1'b1);
        check_eq("neg_max", cnn_data_max, 32'h3F00_0000);

        // valid_out on the expiry cycle, then back-to-back all-zero image.
        run_frame(TMO - 1, 4'd3, 1'b0);
        check_eq("tie_res", result, 32'd3);
        check_eq("tie_err", error, 32'd0);
        for (int k = 0; k < IMG; k++) img[k] = 32'h0;
        run_frame(2, 4'd12, 1'b0);
        check_eq("zero_max", cnn_data_max, 32'h0);

        // Reset mid-STREAM aborts without a done pulse.
        load_random_image();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (999) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("abort");
        rst       = 1'b0;
        res_model = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("abort_done", done, 32'd0);
            check_eq("abort_busy", busy, 32'd0);
        end

        // Randomised frames, including late answers that land after expiry.
        for (int f = 0; f < 3; f++) begin
            load_random_image();
            run_frame(int'($urandom_range(0, TMO + 2)), 4'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
